// File: rtl/osc_voice_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_voice_mixer_pkg
//  Description : Shared synth package for the oscillator TDM consumers.
//                Holds the (voice, osc) slot index struct, the sine and level
//                sample widths, and the signed saturation helper that the
//                mixer and the envelope/VCA blocks both use.
//  Revision    : 1.0 - initial release
// ============================================================================
package osc_voice_mixer_pkg;

    // Sample widths on the osc -> mixer interface.
    localparam int SINE_W    = 17;
    localparam int LVL_W     = 8;

    // Slot index widths for the standard 8-voice x 4-osc frame.
    localparam int SLOT_VX_W = 3;
    localparam int SLOT_OX_W = 2;

    // One TDM slot: which voice and which oscillator of that voice.
    typedef struct packed {
        logic [SLOT_VX_W-1:0] vx;
        logic [SLOT_OX_W-1:0] ox;
    } slot_idx_t;

    // Clamp a signed value to the range of a w-bit two's-complement word
    // (w <= 31). The result is still 32 bits; callers truncate to w.
    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] x,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage : osc_voice_mixer_pkg
`default_nettype wire

// File: rtl/osc_voice_mixer_slot_delay.sv
`default_nettype none
// ============================================================================
//  Module      : osc_voice_mixer_slot_delay
//  Description : DEPTH-deep shift register for a TDM slot index word. Used to
//                line the slot index up with a data sample that arrives
//                DEPTH clocks after the index was issued. Reusable by any
//                TDM consumer on the osc slot clock.
//  Revision    : 1.0 - initial release
//
//  Ports
//    sCLK_XVXOSC   in   1    slot clock
//    reset_data_N  in   1    asynchronous active-low reset, clears all stages
//    d_i           in   W    index word issued this cycle
//    q_o           out  W    index word issued DEPTH cycles ago
// ============================================================================
module osc_voice_mixer_slot_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 6
) (
    input  logic         sCLK_XVXOSC,
    input  logic         reset_data_N,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
        if (!reset_data_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule : osc_voice_mixer_slot_delay
`default_nettype wire

// File: rtl/osc_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : osc_voice_mixer
//  Description : Consumer end of the oscillator TDM sample stream. Realigns
//                the slot index to the sine lookup latency, scales every sine
//                sample by a per-osc level, sums the V_OSC oscillators of each
//                voice and emits one voice sample per voice with a strobe.
//  Revision    : 1.0 - initial release
//
//  Ports
//    sCLK_XVXOSC   in   1         osc slot clock, one (voice,osc) slot/cycle
//    reset_data_N  in   1         asynchronous active-low reset
//    slot_vx       in   V_WIDTH   voice index of the slot issued this cycle
//    slot_ox       in   O_WIDTH   osc index of the slot issued this cycle
//    sine_in       in   17        signed sine sample, LAT cycles behind index
//    voice_free    in   VOICES    1 = voice idle, its output is forced to 0
//    lvl_we        in   1         level write strobe
//    lvl_idx       in   O_WIDTH   osc level to write
//    lvl_data      in   8         unsigned level, 255 = ~unity
//    voice_out     out  OUT_W     signed summed voice sample
//    voice_vx      out  V_WIDTH   voice index of voice_out
//    voice_valid   out  1         1-cycle strobe, voice_out/voice_vx valid
//    frame_start   out  1         strobe with voice_valid for voice 0
//
//  Pipeline (t = cycle in which the aligned index meets sine_in)
//    t    : aligned index from the slot delay line, level lookup
//    t+1  : scaled product registered with its index
//    t+2  : accumulator and output registers updated
// ============================================================================
module osc_voice_mixer
    import osc_voice_mixer_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int LAT     = 2,
    parameter int OUT_W   = 20
) (
    input  logic                 sCLK_XVXOSC,
    input  logic                 reset_data_N,
    input  logic [V_WIDTH-1:0]   slot_vx,
    input  logic [O_WIDTH-1:0]   slot_ox,
    input  logic [SINE_W-1:0]    sine_in,
    input  logic [VOICES-1:0]    voice_free,
    input  logic                 lvl_we,
    input  logic [O_WIDTH-1:0]   lvl_idx,
    input  logic [LVL_W-1:0]     lvl_data,
    output logic [OUT_W-1:0]     voice_out,
    output logic [V_WIDTH-1:0]   voice_vx,
    output logic                 voice_valid,
    output logic                 frame_start
);

    // ------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------
    localparam int c_prod_w = SINE_W + LVL_W + 1;          // 26
    localparam int c_term_w = SINE_W + 1;                  // 18
    localparam int c_acc_w  = c_term_w + $clog2(V_OSC);    // 20
    localparam int c_idx_w  = V_WIDTH + O_WIDTH;
    localparam logic [O_WIDTH-1:0] c_last_ox = O_WIDTH'(V_OSC - 1);

    // ------------------------------------------------------------------
    // Index alignment
    // A 1 is shifted in next to the index so that the zeros flushed out of
    // the delay line right after reset are never mistaken for a real (v0,o0)
    // slot; otherwise sync would lock onto reset debris.
    // ------------------------------------------------------------------
    logic [c_idx_w:0] w_dly_in;
    logic [c_idx_w:0] w_dly_out;
    logic             w_avld;
    slot_idx_t        w_aidx;

    assign w_dly_in = {1'b1, slot_vx, slot_ox};

    osc_voice_mixer_slot_delay #(
        .DEPTH (LAT),
        .W     (c_idx_w + 1)
    ) u_slot_delay (
        .sCLK_XVXOSC  (sCLK_XVXOSC),
        .reset_data_N (reset_data_N),
        .d_i          (w_dly_in),
        .q_o          (w_dly_out)
    );

    assign w_avld = w_dly_out[c_idx_w];
    assign w_aidx = w_dly_out[c_idx_w-1:0];

    // ------------------------------------------------------------------
    // Level registers. Stage 1 reads the current contents in the same cycle
    // a write may land, so a colliding write is seen from the next slot on.
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] lvl_q [V_OSC];

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
        if (!reset_data_N) begin
            for (int i = 0; i < V_OSC; i++) begin
                lvl_q[i] <= '0;
            end
        end else if (lvl_we) begin
            lvl_q[lvl_idx] <= lvl_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: signed sine x unsigned level (level zero-extended to 9 bits)
    // ------------------------------------------------------------------
    logic signed [c_prod_w-1:0] prod_d;
    logic signed [c_prod_w-1:0] prod_q;
    slot_idx_t                  s1_idx_q;
    logic                       s1_vld_q;

    assign prod_d = $signed(sine_in) * $signed({1'b0, lvl_q[w_aidx.ox]});

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
        if (!reset_data_N) begin
            prod_q   <= '0;
            s1_idx_q <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            s1_idx_q <= w_aidx;
            s1_vld_q <= w_avld;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate, saturate, mask and emit
    // ------------------------------------------------------------------
    logic signed [c_term_w-1:0] w_term;
    logic signed [c_acc_w-1:0]  w_term_ext;
    logic signed [c_acc_w-1:0]  acc_d;
    logic signed [c_acc_w-1:0]  acc_q;
    logic                       sync_d;
    logic                       sync_q;
    logic                       w_emit;
    logic [OUT_W-1:0]           voice_out_d;
    logic [OUT_W-1:0]           voice_out_q;
    logic [V_WIDTH-1:0]         voice_vx_d;
    logic [V_WIDTH-1:0]         voice_vx_q;
    logic                       voice_valid_d;
    logic                       voice_valid_q;
    logic                       frame_start_d;
    logic                       frame_start_q;

    // Arithmetic shift drops the 8 fractional bits of the unity level.
    assign w_term     = c_term_w'(prod_q >>> LVL_W);
    assign w_term_ext = {{(c_acc_w - c_term_w){w_term[c_term_w-1]}}, w_term};

    always_comb begin
        acc_d         = acc_q;
        sync_d        = sync_q;
        w_emit        = 1'b0;
        voice_out_d   = voice_out_q;
        voice_vx_d    = voice_vx_q;
        voice_valid_d = 1'b0;
        frame_start_d = 1'b0;

        if (s1_vld_q) begin
            // osc 0 always opens a fresh sum, whatever came before it.
            if (s1_idx_q.ox == '0) begin
                acc_d  = w_term_ext;
                sync_d = 1'b1;
            end else begin
                acc_d  = acc_q + w_term_ext;
            end

            // Only a voice whose osc 0 has been seen since reset is emitted.
            w_emit = (s1_idx_q.ox == c_last_ox) && sync_d;
        end

        if (w_emit) begin
            voice_valid_d = 1'b1;
            voice_vx_d    = s1_idx_q.vx;
            frame_start_d = (s1_idx_q.vx == '0);
            if (voice_free[s1_idx_q.vx]) begin
                voice_out_d = '0;
            end else begin
                voice_out_d = OUT_W'(sat_signed(
                    {{(32 - c_acc_w){acc_d[c_acc_w-1]}}, acc_d}, OUT_W));
            end
        end
    end

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
        if (!reset_data_N) begin
            acc_q         <= '0;
            sync_q        <= 1'b0;
            voice_out_q   <= '0;
            voice_vx_q    <= '0;
            voice_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            sync_q        <= sync_d;
            voice_out_q   <= voice_out_d;
            voice_vx_q    <= voice_vx_d;
            voice_valid_q <= voice_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign voice_out   = voice_out_q;
    assign voice_vx    = voice_vx_q;
    assign voice_valid = voice_valid_q;
    assign frame_start = frame_start_q;

endmodule : osc_voice_mixer
`default_nettype wire

// File: tb/tb_osc_voice_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_osc_voice_mixer
//  Description : Directed self-checking bench for osc_voice_mixer. A second
//                instance built with OUT_W = 18 shares the stimulus and is
//                used for the clamp cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_voice_mixer;

    logic        sCLK_XVXOSC = 1'b0;
    logic        reset_data_N;
    logic [2:0]  slot_vx;
    logic [1:0]  slot_ox;
    logic [16:0] sine_in;
    logic [7:0]  voice_free;
    logic        lvl_we;
    logic [1:0]  lvl_idx;
    logic [7:0]  lvl_data;

    logic [19:0] voice_out;
    logic [2:0]  voice_vx;
    logic        voice_valid;
    logic        frame_start;

    logic [17:0] s_voice_out;
    logic [2:0]  s_voice_vx;
    logic        s_voice_valid;
    logic        s_frame_start;

    always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

    osc_voice_mixer dut (
        .sCLK_XVXOSC  (sCLK_XVXOSC),
        .reset_data_N (reset_data_N),
        .slot_vx      (slot_vx),
        .slot_ox      (slot_ox),
        .sine_in      (sine_in),
        .voice_free   (voice_free),
        .lvl_we       (lvl_we),
        .lvl_idx      (lvl_idx),
        .lvl_data     (lvl_data),
        .voice_out    (voice_out),
        .voice_vx     (voice_vx),
        .voice_valid  (voice_valid),
        .frame_start  (frame_start)
    );

    osc_voice_mixer #(.OUT_W(18)) dut_sat (
        .sCLK_XVXOSC  (sCLK_XVXOSC),
        .reset_data_N (reset_data_N),
        .slot_vx      (slot_vx),
        .slot_ox      (slot_ox),
        .sine_in      (sine_in),
        .voice_free   (voice_free),
        .lvl_we       (lvl_we),
        .lvl_idx      (lvl_idx),
        .lvl_data     (lvl_data),
        .voice_out    (s_voice_out),
        .voice_vx     (s_voice_vx),
        .voice_valid  (s_voice_valid),
        .frame_start  (s_frame_start)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;     // slots issued since reset release
    int nxt      = 0;     // next slot number in the frame, vx*4 + ox
    logic [2:0] hist_vx [0:2047];
    logic [1:0] hist_ox [0:2047];

    // Issue the next frame slot, clock once, settle past the edge.
    // The output visible afterwards belongs to slot index cyc-4.
    task automatic drive();
        logic [4:0] s;
        s       = nxt[4:0];
        slot_vx = s[4:2];
        slot_ox = s[1:0];
        hist_vx[cyc] = s[4:2];
        hist_ox[cyc] = s[1:0];
        @(posedge sCLK_XVXOSC);
        #1;
        lvl_we = 1'b0;
        cyc    = cyc + 1;
        nxt    = (nxt + 1) % 32;
    endtask

    task automatic write_lvl(input int idx, input int val);
        logic [7:0] v;
        logic [1:0] i;
        v        = val[7:0];
        i        = idx[1:0];
        lvl_we   = 1'b1;
        lvl_idx  = i;
        lvl_data = v;
        drive();
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic signed [19:0] exp;
        reset_data_N = 1'b0;
        slot_vx = 3'd0; slot_ox = 2'd0;
        sine_in = 17'd16384;
        voice_free = 8'h00;
        lvl_we = 1'b0; lvl_idx = 2'd0; lvl_data = 8'd0;
        repeat (3) @(posedge sCLK_XVXOSC);
        #1;
        checks++;
        if ({voice_out, voice_vx, voice_valid, frame_start} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got out=%h vx=%0d v=%b fs=%b exp all 0",
                     voice_out, voice_vx, voice_valid, frame_start);
        end
        checks++;
        if ({s_voice_out, s_voice_valid, s_frame_start} !== 20'd0) begin
            failures++;
            $display("FAIL reset_sat_outputs got out=%h v=%b exp 0", s_voice_out, s_voice_valid);
        end

        // Release mid-frame: the first slot issued is (v3,o2).
        reset_data_N = 1'b1;
        cyc = 0;
        nxt = 14;
        exp = 20'sd65280;
        for (int i = 0; i <= 8; i++) begin
            if (i < 4) write_lvl(i, 255);
            else drive();
            if (i < 8) begin
                checks++;
                if (voice_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL sync_no_valid cyc=%0d got=%b exp=0", i, voice_valid);
                end
            end else begin
                checks++;
                if (voice_valid !== 1'b1 || voice_vx !== 3'd4 || voice_out !== exp
                    || frame_start !== 1'b0) begin
                    failures++;
                    $display("FAIL sync_first_valid got v=%b vx=%0d out=%0d fs=%b exp v=1 vx=4 out=%0d fs=0",
                             voice_valid, voice_vx, $signed(voice_out), frame_start, exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_unity();
        int nv = 0;
        int nfs = 0;
        int m;
        logic signed [19:0] exp;
        exp = 20'sd65280;
        for (int i = 0; i < 64; i++) begin
            drive();
            m = cyc - 4;
            if (hist_ox[m] == 2'd3) begin
                nv++;
                checks++;
                if (voice_valid !== 1'b1 || voice_vx !== hist_vx[m] || voice_out !== exp) begin
                    failures++;
                    $display("FAIL unity_voice got v=%b vx=%0d out=%0d exp v=1 vx=%0d out=%0d",
                             voice_valid, voice_vx, $signed(voice_out), hist_vx[m], exp);
                end
                checks++;
                if (frame_start !== (hist_vx[m] == 3'd0)) begin
                    failures++;
                    $display("FAIL unity_frame_start vx=%0d got=%b", hist_vx[m], frame_start);
                end
                if (frame_start === 1'b1) nfs++;
            end else begin
                checks++;
                if (voice_valid !== 1'b0 || frame_start !== 1'b0) begin
                    failures++;
                    $display("FAIL unity_idle got v=%b fs=%b exp 0 0", voice_valid, frame_start);
                end
            end
        end
        checks++;
        if (nv != 16 || nfs != 2) begin
            failures++;
            $display("FAIL unity_counts got valid=%0d fs=%0d exp 16 2", nv, nfs);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_voice_free();
        int m;
        int nv = 0;
        logic signed [19:0] exp;
        voice_free = 8'b0000_0100;
        for (int i = 0; i < 32; i++) begin
            drive();
            m = cyc - 4;
            if (hist_ox[m] == 2'd3) begin
                nv++;
                exp = (hist_vx[m] == 3'd2) ? 20'sd0 : 20'sd65280;
                checks++;
                if (voice_valid !== 1'b1 || voice_vx !== hist_vx[m] || voice_out !== exp) begin
                    failures++;
                    $display("FAIL free_mask got v=%b vx=%0d out=%0d exp vx=%0d out=%0d",
                             voice_valid, voice_vx, $signed(voice_out), hist_vx[m], exp);
                end
            end
        end
        checks++;
        if (nv != 8) begin
            failures++;
            $display("FAIL free_count got=%0d exp=8", nv);
        end
        voice_free = 8'h00;
    endtask

    // ------------------------------------------------------------------
    task automatic test_signed();
        int m;
        logic signed [19:0] exp;
        sine_in = 17'h10000;                 // -65536
        write_lvl(0, 128);
        write_lvl(1, 0);
        write_lvl(2, 0);
        write_lvl(3, 0);
        flush(12);
        exp = -20'sd32768;
        for (int i = 0; i < 32; i++) begin
            drive();
            m = cyc - 4;
            if (hist_ox[m] == 2'd3) begin
                checks++;
                if (voice_valid !== 1'b1 || voice_out !== exp) begin
                    failures++;
                    $display("FAIL signed_neg vx=%0d got v=%b out=%0d exp=%0d",
                             hist_vx[m], voice_valid, $signed(voice_out), exp);
                end
            end
        end
        sine_in = 17'h0FFFF;                 // +65535
        flush(12);
        exp = 20'sd32767;
        for (int i = 0; i < 16; i++) begin
            drive();
            m = cyc - 4;
            if (hist_ox[m] == 2'd3) begin
                checks++;
                if (voice_valid !== 1'b1 || voice_out !== exp) begin
                    failures++;
                    $display("FAIL signed_pos vx=%0d got v=%b out=%0d exp=%0d",
                             hist_vx[m], voice_valid, $signed(voice_out), exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_level_collision();
        int col_v;
        int found = 0;
        logic [2:0] vx_a, vx_b;
        logic [19:0] out_a, out_b;
        logic [2:0] exp_b;
        sine_in = 17'd16384;
        for (int i = 0; i < 4; i++) write_lvl(i, 255);
        flush(12);
        while ((nxt % 4) != 3) drive();
        // (v,o3) issued now -> (v,o1) is aligned and read by stage 1 this edge.
        col_v    = nxt / 4;
        lvl_we   = 1'b1;
        lvl_idx  = 2'd1;
        lvl_data = 8'd0;
        drive();
        for (int i = 0; i < 12 && found < 2; i++) begin
            if (voice_valid === 1'b1) begin
                if (found == 0) begin vx_a = voice_vx; out_a = voice_out; end
                else            begin vx_b = voice_vx; out_b = voice_out; end
                found++;
            end
            if (found < 2) drive();
        end
        checks++;
        if (found != 2) begin
            failures++;
            $display("FAIL collision_timeout got valids=%0d exp=2", found);
        end else begin
            exp_b = 3'(col_v + 1);
            checks++;
            if (vx_a !== 3'(col_v) || out_a !== 20'd65280) begin
                failures++;
                $display("FAIL collision_old_level got vx=%0d out=%0d exp vx=%0d out=65280",
                         vx_a, out_a, col_v);
            end
            checks++;
            if (vx_b !== exp_b || out_b !== 20'd48960) begin
                failures++;
                $display("FAIL collision_new_level got vx=%0d out=%0d exp vx=%0d out=48960",
                         vx_b, out_b, exp_b);
            end
        end
        write_lvl(1, 255);
        flush(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturation();
        int m;
        logic signed [17:0] exp_s;
        logic signed [19:0] exp_w;
        sine_in = 17'h0FFFF;
        flush(12);
        exp_s = 18'sd131071;
        exp_w = 20'sd261116;
        for (int i = 0; i < 16; i++) begin
            drive();
            m = cyc - 4;
            if (hist_ox[m] == 2'd3) begin
                checks++;
                if (s_voice_valid !== 1'b1 || s_voice_vx !== hist_vx[m] || s_voice_out !== exp_s) begin
                    failures++;
                    $display("FAIL sat_pos vx=%0d got v=%b out=%0d exp=%0d",
                             hist_vx[m], s_voice_valid, $signed(s_voice_out), exp_s);
                end
                checks++;
                if (voice_out !== exp_w) begin
                    failures++;
                    $display("FAIL wide_pos got=%0d exp=%0d", $signed(voice_out), exp_w);
                end
            end
        end
        sine_in = 17'h10000;
        flush(12);
        exp_s = -18'sd131072;
        exp_w = -20'sd261120;
        for (int i = 0; i < 16; i++) begin
            drive();
            m = cyc - 4;
            if (hist_ox[m] == 2'd3) begin
                checks++;
                if (s_voice_valid !== 1'b1 || s_voice_out !== exp_s) begin
                    failures++;
                    $display("FAIL sat_neg vx=%0d got v=%b out=%0d exp=%0d",
                             hist_vx[m], s_voice_valid, $signed(s_voice_out), exp_s);
                end
                checks++;
                if (voice_out !== exp_w) begin
                    failures++;
                    $display("FAIL wide_neg got=%0d exp=%0d", $signed(voice_out), exp_w);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_voice_free();
        test_signed();
        test_level_collision();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_osc_voice_mixer
`default_nettype wire
